// File: rtl/qtr_emu_pkg.sv
// Shared definitions for the QTR reflectance-channel emulator: FSM state
// encoding, tick length and the largest reflectance value the host can read.
package qtr_emu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHARGE = 2'd1,
      DECAY  = 2'd2
   } qtr_state_t;

   localparam int QTR_TICK_US   = 10;
   localparam int QTR_MAX_VALUE = 255;

   // Clock cycles in one decay tick for a given system clock.
   function automatic int qtr_tick_cycles(input int clk_hz);
      return clk_hz / (1_000_000 / QTR_TICK_US);
   endfunction

endpackage

// File: rtl/qtr_emu_if.sv
// Sensor-side bus of one QTR channel: host line drive, host CTRL pin, the
// reflectance load port and the emulator status outputs.
// master = host / test harness, slave = emulator.
interface qtr_emu_if;
   logic [7:0] value_in;
   logic       value_wr;
   logic       host_oe;
   logic       host_sig;
   logic       host_ctrl;
   logic       line_out;
   logic       decay_active;
   logic       charge_ok;
   logic       done;
   logic [7:0] cur_value;

   modport master (
      output value_in, value_wr, host_oe, host_sig, host_ctrl,
      input  line_out, decay_active, charge_ok, done, cur_value
   );

   modport slave (
      input  value_in, value_wr, host_oe, host_sig, host_ctrl,
      output line_out, decay_active, charge_ok, done, cur_value
   );
endinterface

// File: rtl/qtr_emu_tick_gen_10us.sv
// Restartable prescaler: counts 0..TEN_US_COUNT-1 while enabled and flags the
// last count of each period with a one-cycle tick. restart is synchronous and
// wins over enable.
module tick_gen_10us #(
   parameter int TEN_US_COUNT = 600
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   input  logic en,
   output logic tick
);
   localparam int PW = (TEN_US_COUNT > 1) ? $clog2(TEN_US_COUNT) : 1;
   localparam logic [PW-1:0] LAST = PW'(TEN_US_COUNT - 1);

   logic [PW-1:0] cnt;

   // Prescaler counter, wraps at LAST.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       cnt <= '0;
      else if (restart)   cnt <= '0;
      else if (en)        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign tick = en && (cnt == LAST);
endmodule

// File: rtl/qtr_emu.sv
// QTR reflectance-channel emulator (sensor end of the charge/decay timing
// interface). Detects the host charge pulse, then holds the line high for
// cur_value ticks of 10 us before releasing it.
// Optional build macro QTR_EMU_CTRL_EN: when defined, host_ctrl=0 at commit
// time (LED off) forces the decay to the maximum value.
module qtr_emu
   import qtr_emu_pkg::*;
#(
   parameter int CLK_FREQUENCY    = 60_000_000,
   parameter int TEN_US_COUNT     = qtr_tick_cycles(CLK_FREQUENCY),
   parameter int CHARGE_MIN_COUNT = TEN_US_COUNT
) (
   input  logic     clk,
   input  logic     reset_n,
   qtr_emu_if.slave bus
);
   localparam int CW = $clog2(CHARGE_MIN_COUNT + 1);
   localparam logic [CW-1:0] CHARGE_FULL = CW'(CHARGE_MIN_COUNT);

   qtr_state_t    state, state_nxt;
   logic [CW-1:0] charge_cnt, charge_cnt_nxt, charge_start;
   logic [7:0]    tick_cnt, tick_cnt_nxt;
   logic [7:0]    cur_value_q, cur_value_nxt;
   logic [7:0]    shadow, commit_val;
   logic          emu_drive, emu_drive_nxt;
   logic          done_q, done_nxt;
   logic          charge_ok_q, charge_ok_nxt;
   logic          presc_restart, tick, decay_en;

`ifdef QTR_EMU_CTRL_EN
   assign commit_val = bus.host_ctrl ? shadow : 8'(QTR_MAX_VALUE);
`else
   // host_ctrl is deliberately ignored in this build.
   logic unused_host_ctrl;
   assign unused_host_ctrl = bus.host_ctrl;
   assign commit_val       = shadow;
`endif

   // The first driven cycle of a charge already counts toward the minimum.
   assign charge_start = bus.host_sig ? CW'(1) : '0;
   assign decay_en     = (state == DECAY);

   tick_gen_10us #(.TEN_US_COUNT(TEN_US_COUNT)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (presc_restart),
      .en      (decay_en),
      .tick    (tick)
   );

   // Shadow register accepts writes in every state; only commit reads it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          shadow <= '0;
      else if (bus.value_wr) shadow <= bus.value_in;
   end

   // FSM and datapath state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         charge_cnt  <= '0;
         tick_cnt    <= '0;
         cur_value_q <= '0;
         emu_drive   <= 1'b0;
         done_q      <= 1'b0;
         charge_ok_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         charge_cnt  <= charge_cnt_nxt;
         tick_cnt    <= tick_cnt_nxt;
         cur_value_q <= cur_value_nxt;
         emu_drive   <= emu_drive_nxt;
         done_q      <= done_nxt;
         charge_ok_q <= charge_ok_nxt;
      end
   end

   // Next-state: charge qualification, commit on release, tick-timed decay.
   always_comb begin
      state_nxt      = state;
      charge_cnt_nxt = charge_cnt;
      tick_cnt_nxt   = tick_cnt;
      cur_value_nxt  = cur_value_q;
      emu_drive_nxt  = emu_drive;
      done_nxt       = 1'b0;
      charge_ok_nxt  = charge_ok_q;
      presc_restart  = 1'b0;
      case (state)
         IDLE: begin
            emu_drive_nxt = 1'b0;
            if (bus.host_oe) begin
               state_nxt      = CHARGE;
               charge_cnt_nxt = charge_start;
            end
         end
         CHARGE: begin
            if (bus.host_oe) begin
               if (!bus.host_sig)                charge_cnt_nxt = '0;
               else if (charge_cnt != CHARGE_FULL) charge_cnt_nxt = charge_cnt + 1'b1;
            end else if (charge_cnt == CHARGE_FULL) begin
               charge_ok_nxt = 1'b1;
               cur_value_nxt = commit_val;
               presc_restart = 1'b1;
               tick_cnt_nxt  = '0;
               if (commit_val == 8'd0) begin
                  emu_drive_nxt = 1'b0;
                  done_nxt      = 1'b1;
                  state_nxt     = IDLE;
               end else begin
                  emu_drive_nxt = 1'b1;
                  state_nxt     = DECAY;
               end
            end else begin
               charge_ok_nxt = 1'b0;
               emu_drive_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         DECAY: begin
            if (bus.host_oe) begin
               // Host re-charges mid-decay: abandon this decay silently.
               state_nxt      = CHARGE;
               charge_cnt_nxt = charge_start;
               emu_drive_nxt  = 1'b0;
            end else if (tick) begin
               if (tick_cnt == cur_value_q - 8'd1) begin
                  emu_drive_nxt = 1'b0;
                  done_nxt      = 1'b1;
                  state_nxt     = IDLE;
               end else begin
                  tick_cnt_nxt = tick_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Wired bus: the host wins whenever it drives the line.
   assign bus.line_out     = bus.host_oe ? bus.host_sig : emu_drive;
   assign bus.decay_active = decay_en;
   assign bus.charge_ok    = charge_ok_q;
   assign bus.done         = done_q;
   assign bus.cur_value    = cur_value_q;
endmodule

// File: tb/tb_qtr_emu.sv
// Bench for qtr_emu at CLK_FREQUENCY=600_000 (6-cycle tick, 6-cycle minimum
// charge). Reference behaviour is modelled from the emulator rules in plain
// arithmetic: a valid charge is a trailing run of >=6 driven-high cycles, and
// the line then stays high value*6 cycles followed by a single done pulse.
module tb_qtr_emu;
   localparam int CLK_FREQUENCY = 600_000;
   localparam int TEN_US        = CLK_FREQUENCY / 100_000;
   localparam int CHARGE_MIN    = TEN_US;

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   // Reference model state.
   int   m_shadow = 0;
   int   m_cur    = 0;
   int   m_ok     = 0;

   // Per-cycle samples.
   logic s_line, s_done, s_act;

   qtr_emu_if bus();

   qtr_emu #(.CLK_FREQUENCY(CLK_FREQUENCY)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at the falling edge, return just after the rising edge.
   task automatic clk_cycle();
      @(negedge clk);
      s_line = bus.line_out;
      s_done = bus.done;
      s_act  = bus.decay_active;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] v);
      bus.value_in = v;
      bus.value_wr = 1'b1;
      clk_cycle();
      bus.value_wr = 1'b0;
      m_shadow = v;
   endtask

   // Drive a charge of len cycles (host_sig low at index low_at, if in range),
   // then release; returns after the first released cycle.
   task automatic charge(input int len, input int low_at);
      bus.host_oe = 1'b1;
      for (int i = 0; i < len; i++) begin
         bus.host_sig = (i == low_at) ? 1'b0 : 1'b1;
         clk_cycle();
         if (i == 0) chk("host_path", s_line, 1);
      end
      bus.host_oe  = 1'b0;
      bus.host_sig = 1'b0;
      clk_cycle();
   endtask

   task automatic measure(input int window, input int wr_at, input logic [7:0] wr_val,
                          output int hi, output int dn, output int dn_idx,
                          output int last_hi, output logic act1);
      hi = 0; dn = 0; dn_idx = -1; last_hi = 0; act1 = 1'b0;
      for (int i = 1; i <= window; i++) begin
         bus.value_wr = (i == wr_at);
         if (i == wr_at) bus.value_in = wr_val;
         clk_cycle();
         if (i == 1) act1 = s_act;
         if (s_line) begin hi++; last_hi = i; end
         if (s_done) begin dn++; dn_idx = i; end
      end
      bus.value_wr = 1'b0;
   endtask

   function automatic int trailing_ones(input int len, input int low_at);
      if (low_at >= 0 && low_at < len) return len - low_at - 1;
      return len;
   endfunction

   task automatic full_decay(input string tag, input int len, input int low_at,
                             input int wr_at, input logic [7:0] wr_val);
      int   exp_v, exp_hi, window, hi, dn, di, lh;
      logic act1;
      bit   valid;
      valid = trailing_ones(len, low_at) >= CHARGE_MIN;
      exp_v = m_shadow;
`ifdef QTR_EMU_CTRL_EN
      if (bus.host_ctrl == 1'b0) exp_v = 255;
`endif
      charge(len, low_at);
      chk($sformatf("%s_rel", tag), s_line, 0);
      if (valid) begin
         m_cur = exp_v;
         m_ok  = 1;
      end else begin
         m_ok  = 0;
      end
      exp_hi = valid ? exp_v * TEN_US : 0;
      window = valid ? exp_hi + 4 : 8;
      measure(window, wr_at, wr_val, hi, dn, di, lh, act1);
      if (wr_at >= 1 && wr_at <= window) m_shadow = wr_val;
      chk($sformatf("%s_high", tag), hi, exp_hi);
      chk($sformatf("%s_contig", tag), lh, exp_hi);
      chk($sformatf("%s_done_cnt", tag), dn, valid ? 1 : 0);
      if (valid) chk($sformatf("%s_done_idx", tag), di, exp_hi + 1);
      chk($sformatf("%s_act1", tag), act1, (valid && exp_v > 0) ? 1 : 0);
      chk($sformatf("%s_cur", tag), bus.cur_value, m_cur);
      chk($sformatf("%s_ok", tag), bus.charge_ok, m_ok);
      chk($sformatf("%s_idle", tag), bus.decay_active, 0);
   endtask

   initial begin
      int          hi, dn, di, lh, len, low_at, wr_at;
      logic        act1;
      logic [7:0]  v;

      reset_n       = 1'b0;
      bus.value_in  = '0;
      bus.value_wr  = 1'b0;
      bus.host_oe   = 1'b0;
      bus.host_sig  = 1'b0;
      bus.host_ctrl = 1'b1;
      repeat (3) clk_cycle();
      chk("rst_line", s_line, 0);
      chk("rst_done", s_done, 0);
      chk("rst_act", bus.decay_active, 0);
      chk("rst_ok", bus.charge_ok, 0);
      chk("rst_cur", bus.cur_value, 0);
      reset_n = 1'b1;
      clk_cycle();

      // Basic decay, short charge, charge interrupted by a low host level.
      wr(8'd20);
      full_decay("basic", 6, -1, 0, 8'd0);
      full_decay("short", 4, -1, 0, 8'd0);
      full_decay("sigdrop", 11, 5, 0, 8'd0);
      full_decay("longchg", 9, 2, 0, 8'd0);

      // Boundary values.
      wr(8'd0);
      full_decay("v0", 6, -1, 0, 8'd0);
      wr(8'd255);
      full_decay("v255", 7, -1, 0, 8'd0);

      // Write during a running decay only affects the next one.
      wr(8'd50);
      full_decay("wrmid", 6, -1, 100, 8'd10);
      full_decay("after_wr", 6, -1, 0, 8'd0);

      // Abort at decay cycle 30; the abort cycle itself counts toward the next charge.
      charge(6, -1);
      m_cur = m_shadow; m_ok = 1;
      measure(29, 0, 8'd0, hi, dn, di, lh, act1);
      chk("abort_pre_high", hi, 29);
      bus.host_oe  = 1'b1;
      bus.host_sig = 1'b1;
      clk_cycle();
      chk("abort_host_line", s_line, 1);
      chk("abort_no_done", s_done, 0);
      dn = 0;
      for (int i = 0; i < 5; i++) begin
         clk_cycle();
         if (i == 0) chk("abort_left_decay", s_act, 0);
         if (s_done) dn++;
      end
      chk("abort_done_cnt", dn, 0);
      bus.host_oe  = 1'b0;
      bus.host_sig = 1'b0;
      clk_cycle();
      measure(m_shadow * TEN_US + 4, 0, 8'd0, hi, dn, di, lh, act1);
      chk("abort_recharge_high", hi, m_shadow * TEN_US);
      chk("abort_recharge_done", dn, 1);

      // Asynchronous reset in the middle of a decay.
      wr(8'd30);
      charge(6, -1);
      measure(40, 0, 8'd0, hi, dn, di, lh, act1);
      chk("rstmid_pre_high", s_line, 1);
      #3 reset_n = 1'b0;
      #1;
      chk("rstmid_line", bus.line_out, 0);
      chk("rstmid_act", bus.decay_active, 0);
      chk("rstmid_ok", bus.charge_ok, 0);
      chk("rstmid_done", bus.done, 0);
      chk("rstmid_cur", bus.cur_value, 0);
      m_shadow = 0; m_cur = 0; m_ok = 0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      clk_cycle();
      full_decay("post_rst", 6, -1, 0, 8'd0);

      // LED-enable pin at commit time.
      bus.host_ctrl = 1'b0;
      wr(8'd20);
      full_decay("ctrl0", 6, -1, 0, 8'd0);
      bus.host_ctrl = 1'b1;
      full_decay("ctrl1", 6, -1, 0, 8'd0);

      // Randomized transactions.
      for (int n = 0; n < 8; n++) begin
         v = 8'($urandom_range(1, 30));
         wr(v);
         len    = $urandom_range(3, 9);
         low_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         wr_at  = $urandom_range(0, 20);
         full_decay($sformatf("rnd%0d", n), len, low_at, wr_at, 8'($urandom_range(1, 30)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
